wb_assoc_cache: RTL and testbench

- Self-contained N-way set-associative write-back cache: lookup, victim selection, write-back, fill and flush FSM, with internal tag/valid/dirty/PLRU/data storage.
- Sits between the CPU bus adapter (256-bit line interface) and the cacheline adapter.
- Generalises the earlier split datapath/control cache:
  - any way degree 1..3;
  - invalid-way-first victim selection;
  - a full-cache flush operation.

---
 rtl/wb_assoc_cache.sv | 273 +++++++++++++++++++++++++++
 tb/tb_wb_assoc_cache.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_assoc_cache.sv
// N-way set-associative write-back cache with PLRU replacement, dirty write-back, fill and full flush.
// Optional hit/miss counters are enabled by defining CACHE_PERF_CNT_EN.
module wb_assoc_cache #(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int WAY_DEG  = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_addr,
    input  logic [255:0] mem_wdata256,
    input  logic [31:0]  mem_byte_enable256,
    output logic [255:0] mem_rdata256,
    output logic         mem_resp,
    output logic         ca_read,
    output logic         ca_write,
    output logic [31:0]  ca_addr,
    output logic [255:0] ca_wdata,
    input  logic [255:0] ca_rdata,
    input  logic         ca_resp,
    input  logic         flush_req,
    output logic         flush_done
`ifdef CACHE_PERF_CNT_EN
    ,
    output logic [31:0]  hit_count,
    output logic [31:0]  miss_count
`endif
);

    localparam int SETS   = 2**S_INDEX;
    localparam int WAYS   = 2**WAY_DEG;
    localparam int PLRU_W = WAYS - 1;
    localparam int TAG_W  = 32 - S_OFFSET - S_INDEX;
    localparam int SCAN_W = S_INDEX + WAY_DEG;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CHECK    = 3'd1,
        ST_WB       = 3'd2,
        ST_FILL     = 3'd3,
        ST_FLUSH    = 3'd4,
        ST_FLUSH_WB = 3'd5
    } state_e;

    state_e              state_r;
    logic [TAG_W-1:0]    tag_r   [SETS][WAYS];
    logic [255:0]        data_r  [SETS][WAYS];
    logic [WAYS-1:0]     valid_r [SETS];
    logic [WAYS-1:0]     dirty_r [SETS];
    logic [PLRU_W-1:0]   plru_r  [SETS];
    logic [WAY_DEG-1:0]  victim_r;
    logic [SCAN_W-1:0]   flush_idx_r;

    logic [TAG_W-1:0]    tag_s;
    logic [S_INDEX-1:0]  idx_s;
    logic                req_s;
    logic                hit_s;
    logic [WAY_DEG-1:0]  hit_way_s;
    logic                inv_s;
    logic [WAY_DEG-1:0]  inv_way_s;
    logic [WAY_DEG-1:0]  victim_s;
    logic [S_INDEX-1:0]  flush_set_s;
    logic [WAY_DEG-1:0]  flush_way_s;
    logic                flush_dirty_s;
    logic                flush_last_s;
    logic                unused_addr_s;

    function automatic logic [255:0] merge_line(input logic [255:0] old_line,
                                                input logic [255:0] new_line,
                                                input logic [31:0]  be);
        logic [255:0] m;
        m = old_line;
        for (int b = 0; b < 32; b++) begin
            m[8*b +: 8] = be[b] ? new_line[8*b +: 8] : old_line[8*b +: 8];
        end
        return m;
    endfunction

    // Walk the heap-ordered tree from the root; a 0 bit steers toward the lower half.
    function automatic logic [WAY_DEG-1:0] plru_victim(input logic [PLRU_W-1:0] tree);
        int                 node;
        logic               bit_v;
        logic [WAY_DEG-1:0] way_v;
        node  = 0;
        way_v = '0;
        for (int l = 0; l < WAY_DEG; l++) begin
            bit_v = 1'b0;
            for (int j = 0; j < PLRU_W; j++) begin
                bit_v = (j == node) ? tree[j] : bit_v;
            end
            way_v[WAY_DEG-1-l] = bit_v;
            node = 2 * node + 1 + int'(bit_v);
        end
        return way_v;
    endfunction

    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] tree,
                                                     input logic [WAY_DEG-1:0] way);
        int                node;
        logic              bit_v;
        logic [PLRU_W-1:0] t;
        t    = tree;
        node = 0;
        for (int l = 0; l < WAY_DEG; l++) begin
            bit_v = way[WAY_DEG-1-l];
            for (int j = 0; j < PLRU_W; j++) begin
                t[j] = (j == node) ? ~bit_v : t[j];
            end
            node = 2 * node + 1 + int'(bit_v);
        end
        return t;
    endfunction

    assign tag_s         = mem_addr[31:S_OFFSET+S_INDEX];
    assign idx_s         = mem_addr[S_OFFSET+S_INDEX-1:S_OFFSET];
    assign req_s         = mem_read | mem_write;
    assign flush_set_s   = flush_idx_r[SCAN_W-1:WAY_DEG];
    assign flush_way_s   = flush_idx_r[WAY_DEG-1:0];
    assign flush_dirty_s = valid_r[flush_set_s][flush_way_s] & dirty_r[flush_set_s][flush_way_s];
    assign flush_last_s  = &flush_idx_r;
    // The cache is line-granular, so the byte-offset bits never take part in lookup.
    assign unused_addr_s = ^mem_addr[S_OFFSET-1:0];

    // Tag compare and victim choice; scanning downward makes the lowest matching/invalid way win.
    always_comb begin
        hit_s     = 1'b0;
        hit_way_s = '0;
        inv_s     = 1'b0;
        inv_way_s = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            logic match_v;
            match_v   = valid_r[idx_s][w] & (tag_r[idx_s][w] == tag_s);
            hit_s     = hit_s | match_v;
            hit_way_s = match_v ? WAY_DEG'(w) : hit_way_s;
            inv_s     = inv_s | ~valid_r[idx_s][w];
            inv_way_s = ~valid_r[idx_s][w] ? WAY_DEG'(w) : inv_way_s;
        end
        victim_s = inv_s ? inv_way_s : plru_victim(plru_r[idx_s]);
    end

    // Controller FSM with all arrays and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            victim_r     <= '0;
            flush_idx_r  <= '0;
            mem_resp     <= 1'b0;
            mem_rdata256 <= '0;
            ca_read      <= 1'b0;
            ca_write     <= 1'b0;
            ca_addr      <= '0;
            ca_wdata     <= '0;
            flush_done   <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= '0;
                dirty_r[s] <= '0;
                plru_r[s]  <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    tag_r[s][w]  <= '0;
                    data_r[s][w] <= '0;
                end
            end
`ifdef CACHE_PERF_CNT_EN
            hit_count  <= 32'd0;
            miss_count <= 32'd0;
`endif
        end else begin
            mem_resp   <= 1'b0;
            flush_done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (flush_req) begin
                        flush_idx_r <= '0;
                        state_r     <= ST_FLUSH;
                    end else if (req_s) begin
                        state_r <= ST_CHECK;
                        // Lookup runs a cycle early so the hit response is a flop during CHECK.
                        if (hit_s) begin
                            mem_resp       <= 1'b1;
                            mem_rdata256   <= data_r[idx_s][hit_way_s];
                            plru_r[idx_s]  <= plru_touch(plru_r[idx_s], hit_way_s);
                            if (mem_write) begin
                                data_r[idx_s][hit_way_s]  <= merge_line(data_r[idx_s][hit_way_s],
                                                                        mem_wdata256, mem_byte_enable256);
                                dirty_r[idx_s][hit_way_s] <= 1'b1;
                            end
`ifdef CACHE_PERF_CNT_EN
                            hit_count <= hit_count + 32'd1;
`endif
                        end
                    end
                end
                ST_CHECK: begin
                    if (mem_resp) begin
                        state_r <= ST_IDLE;
                    end else begin
                        victim_r <= victim_s;
`ifdef CACHE_PERF_CNT_EN
                        miss_count <= miss_count + 32'd1;
`endif
                        if (valid_r[idx_s][victim_s] && dirty_r[idx_s][victim_s]) begin
                            ca_write <= 1'b1;
                            ca_addr  <= {tag_r[idx_s][victim_s], idx_s, {S_OFFSET{1'b0}}};
                            ca_wdata <= data_r[idx_s][victim_s];
                            state_r  <= ST_WB;
                        end else begin
                            ca_read <= 1'b1;
                            ca_addr <= {mem_addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
                            state_r <= ST_FILL;
                        end
                    end
                end
                ST_WB: begin
                    if (ca_resp) begin
                        ca_write <= 1'b0;
                        ca_read  <= 1'b1;
                        ca_addr  <= {mem_addr[31:S_OFFSET], {S_OFFSET{1'b0}}};
                        state_r  <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // The re-check after a fill always hits the victim way, so it is answered here.
                    if (ca_resp) begin
                        ca_read                  <= 1'b0;
                        tag_r[idx_s][victim_r]   <= tag_s;
                        valid_r[idx_s][victim_r] <= 1'b1;
                        dirty_r[idx_s][victim_r] <= mem_write;
                        data_r[idx_s][victim_r]  <= mem_write ?
                            merge_line(ca_rdata, mem_wdata256, mem_byte_enable256) : ca_rdata;
                        plru_r[idx_s]            <= plru_touch(plru_r[idx_s], victim_r);
                        mem_resp                 <= 1'b1;
                        mem_rdata256             <= ca_rdata;
                        state_r                  <= ST_CHECK;
                    end
                end
                ST_FLUSH: begin
                    if (flush_dirty_s) begin
                        ca_write <= 1'b1;
                        ca_addr  <= {tag_r[flush_set_s][flush_way_s], flush_set_s, {S_OFFSET{1'b0}}};
                        ca_wdata <= data_r[flush_set_s][flush_way_s];
                        state_r  <= ST_FLUSH_WB;
                    end else if (flush_last_s) begin
                        flush_done <= 1'b1;
                        state_r    <= ST_IDLE;
                    end else begin
                        flush_idx_r <= flush_idx_r + SCAN_W'(1);
                    end
                end
                ST_FLUSH_WB: begin
                    if (ca_resp) begin
                        ca_write                             <= 1'b0;
                        dirty_r[flush_set_s][flush_way_s]    <= 1'b0;
                        if (flush_last_s) begin
                            flush_done <= 1'b1;
                            state_r    <= ST_IDLE;
                        end else begin
                            flush_idx_r <= flush_idx_r + SCAN_W'(1);
                            state_r     <= ST_FLUSH;
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    ca_read  <= 1'b0;
                    ca_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_assoc_cache.sv
// Scoreboard bench for wb_assoc_cache (4-way, 8 sets): upstream read data and downstream
// transactions are queued as expectations when stimulus is driven and compared when they occur.
module tb_wb_assoc_cache;

    localparam int S_OFFSET = 5;
    localparam int S_INDEX  = 3;
    localparam int WAY_DEG  = 2;

    logic         clk;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata256;
    logic [31:0]  mem_byte_enable256;
    logic [255:0] mem_rdata256;
    logic         mem_resp;
    logic         ca_read;
    logic         ca_write;
    logic [31:0]  ca_addr;
    logic [255:0] ca_wdata;
    logic [255:0] ca_rdata;
    logic         ca_resp;
    logic         flush_req;
    logic         flush_done;

    int n_checks;
    int n_errors;

    typedef struct {
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] data;
    } ds_txn_t;

    ds_txn_t      exp_ds[$];
    logic [255:0] exp_rd[$];
    logic [255:0] golden [bit [26:0]];
    logic [255:0] dsmem  [bit [26:0]];
    bit           ds_enable;
    int           wait_cnt;

    wb_assoc_cache #(
        .S_OFFSET (S_OFFSET),
        .S_INDEX  (S_INDEX),
        .WAY_DEG  (WAY_DEG)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_addr           (mem_addr),
        .mem_wdata256       (mem_wdata256),
        .mem_byte_enable256 (mem_byte_enable256),
        .mem_rdata256       (mem_rdata256),
        .mem_resp           (mem_resp),
        .ca_read            (ca_read),
        .ca_write           (ca_write),
        .ca_addr            (ca_addr),
        .ca_wdata           (ca_wdata),
        .ca_rdata           (ca_rdata),
        .ca_resp            (ca_resp),
        .flush_req          (flush_req),
        .flush_done         (flush_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Backing-store content for lines never written: line 0x40 is all 0xA5, others encode their address.
    function automatic logic [255:0] pattern(input bit [26:0] line);
        if (line == 27'h2) return {32{8'hA5}};
        return {8{line, 5'b00000}};
    endfunction

    function automatic logic [255:0] get_golden(input bit [26:0] line);
        if (golden.exists(line)) return golden[line];
        return pattern(line);
    endfunction

    function automatic logic [255:0] ds_get(input bit [26:0] line);
        if (dsmem.exists(line)) return dsmem[line];
        return pattern(line);
    endfunction

    function automatic logic [255:0] merge_ref(input logic [255:0] old_l, input logic [255:0] new_l,
                                               input logic [31:0] be);
        logic [255:0] r;
        r = old_l;
        for (int b = 0; b < 32; b++) begin
            if (be[b]) r[b*8 +: 8] = new_l[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic push_ds(input bit wr, input logic [31:0] addr, input logic [255:0] data);
        ds_txn_t t;
        t.wr   = wr;
        t.addr = addr;
        t.data = data;
        exp_ds.push_back(t);
    endtask

    task automatic serve_ds();
        ds_txn_t t;
        check_eq("ds_expected", exp_ds.size() != 0, 1'b1);
        if (exp_ds.size() != 0) begin
            t = exp_ds.pop_front();
            check_eq("ds_kind", ca_write, t.wr);
            check_eq("ds_addr", ca_addr, t.addr);
            if (t.wr) check_eq("ds_wdata", ca_wdata, t.data);
        end
        if (ca_write) dsmem[ca_addr[31:5]] = ca_wdata;
        else ca_rdata = ds_get(ca_addr[31:5]);
        ca_resp = 1'b1;
    endtask

    // Downstream responder: answers each request after three cycles with a one-cycle ca_resp.
    initial begin : downstream
        ca_resp  = 1'b0;
        ca_rdata = '0;
        wait_cnt = 0;
        forever begin
            @(posedge clk); #1;
            if (ca_read || ca_write) begin
                wait_cnt++;
                if (ds_enable && wait_cnt >= 3) begin
                    serve_ds();
                    wait_cnt = 0;
                    @(posedge clk); #1;
                    ca_resp = 1'b0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic access(input bit wr, input logic [31:0] addr, input logic [255:0] wd,
                          input logic [31:0] be, output int lat);
        bit [26:0]    line;
        logic [255:0] exp;
        line = addr[31:5];
        if (wr) golden[line] = merge_ref(get_golden(line), wd, be);
        else exp_rd.push_back(get_golden(line));
        mem_addr           = addr;
        mem_wdata256       = wd;
        mem_byte_enable256 = be;
        mem_read           = !wr;
        mem_write          = wr;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!mem_resp && lat < 300);
        check_eq("resp_seen", mem_resp, 1'b1);
        if (!wr) begin
            exp = exp_rd.pop_front();
            if (mem_resp) check_eq("rdata", mem_rdata256, exp);
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_flush(output int cyc);
        flush_req = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!flush_done && cyc < 3000);
        check_eq("flush_done_seen", flush_done, 1'b1);
        flush_req = 1'b0;
        @(posedge clk); #1;
        check_eq("flush_done_pulse", flush_done, 1'b0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin : main
        int           lat;
        int           cyc;
        logic [255:0] wd;
        logic [31:0]  a;
        n_checks           = 0;
        n_errors           = 0;
        ds_enable          = 1'b1;
        rst                = 1'b0;
        mem_read           = 1'b0;
        mem_write          = 1'b0;
        mem_addr           = '0;
        mem_wdata256       = '0;
        mem_byte_enable256 = '0;
        flush_req          = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_mem_resp", mem_resp, 1'b0);
        check_eq("rst_ca_read", ca_read, 1'b0);
        check_eq("rst_ca_write", ca_write, 1'b0);
        check_eq("rst_flush_done", flush_done, 1'b0);
        check_eq("rst_ca_addr", ca_addr, 32'h0);
        check_eq("rst_rdata", mem_rdata256, 256'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Cold read, then a hit one cycle after the request is seen.
        push_ds(1'b0, 32'h0000_0040, '0);
        access(1'b0, 32'h0000_0040, '0, '0, lat);
        check_eq("cold_miss_lat", lat > 1, 1'b1);
        check_eq("ds_drained_cold", exp_ds.size(), 0);
        access(1'b0, 32'h0000_0040, '0, '0, lat);
        check_eq("hit_lat", lat, 1);

        // Single-byte write hit, then read back the merged line without downstream traffic.
        wd = '0;
        wd[7:0] = 8'h3C;
        access(1'b1, 32'h0000_0040, wd, 32'h0000_0001, lat);
        check_eq("write_hit_lat", lat, 1);
        access(1'b0, 32'h0000_0040, '0, '0, lat);
        check_eq("read_after_write_lat", lat, 1);
        check_eq("ds_drained_write", exp_ds.size(), 0);

        // Flush of the single dirty line writes the merged data back.
        push_ds(1'b1, 32'h0000_0040, get_golden(27'h2));
        do_flush(cyc);
        check_eq("ds_drained_flush1", exp_ds.size(), 0);

        // PLRU: fill four tags in set 3, touch T0; the next miss must replace way 2 (tag 3).
        for (int i = 1; i <= 4; i++) begin
            a = (32'(i) << 8) | 32'h60;
            push_ds(1'b0, a, '0);
            access(1'b0, a, '0, '0, lat);
        end
        access(1'b0, 32'h0000_0160, '0, '0, lat);
        check_eq("plru_t0_hit", lat, 1);
        push_ds(1'b0, 32'h0000_0560, '0);
        access(1'b0, 32'h0000_0560, '0, '0, lat);
        access(1'b0, 32'h0000_0160, '0, '0, lat);
        check_eq("plru_keep_t0", lat, 1);
        access(1'b0, 32'h0000_0260, '0, '0, lat);
        check_eq("plru_keep_t1", lat, 1);
        access(1'b0, 32'h0000_0460, '0, '0, lat);
        check_eq("plru_keep_t3", lat, 1);
        push_ds(1'b0, 32'h0000_0360, '0);
        access(1'b0, 32'h0000_0360, '0, '0, lat);
        check_eq("plru_evicted_way2", lat > 1, 1'b1);
        check_eq("ds_drained_plru", exp_ds.size(), 0);

        // Dirty victim in set 4: way 2 is dirtied, PLRU steered to it, new tag forces WB then fill.
        for (int i = 1; i <= 3; i++) begin
            a = (32'(i) << 8) | 32'h80;
            push_ds(1'b0, a, '0);
            access(1'b0, a, '0, '0, lat);
        end
        access(1'b1, 32'h0000_0380, {8{32'hDEAD_BEEF}}, 32'hF000_000F, lat);
        check_eq("dirty_write_hit_lat", lat, 1);
        push_ds(1'b0, 32'h0000_0480, '0);
        access(1'b0, 32'h0000_0480, '0, '0, lat);
        access(1'b0, 32'h0000_0180, '0, '0, lat);
        check_eq("dirty_t1_hit", lat, 1);
        push_ds(1'b1, 32'h0000_0380, get_golden(27'h1C));
        push_ds(1'b0, 32'h0000_0580, '0);
        access(1'b0, 32'h0000_0580, '0, '0, lat);
        check_eq("ds_drained_dirty", exp_ds.size(), 0);

        // Dirty lines in sets 5 and 1 (issued in that order) are flushed in set order.
        push_ds(1'b0, 32'h0000_07A0, '0);
        access(1'b1, 32'h0000_07A0, {8{32'h1234_5678}}, 32'h00FF_0000, lat);
        push_ds(1'b0, 32'h0000_0720, '0);
        access(1'b1, 32'h0000_0720, {8{32'hCAFE_F00D}}, 32'h8000_0001, lat);
        push_ds(1'b1, 32'h0000_0720, get_golden(27'h39));
        push_ds(1'b1, 32'h0000_07A0, get_golden(27'h3D));
        do_flush(cyc);
        check_eq("ds_drained_flush2", exp_ds.size(), 0);

        // Clean flush: one cycle to leave IDLE plus one scan cycle per (set, way) pair.
        do_flush(cyc);
        check_eq("clean_flush_cycles", cyc, 1 + (2**S_INDEX) * (2**WAY_DEG));
        check_eq("ds_drained_flush3", exp_ds.size(), 0);

        // Reset during a fill drops ca_read at once and leaves the cache empty.
        ds_enable = 1'b0;
        mem_addr  = 32'h0000_0900;
        mem_read  = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!ca_read && cyc < 50);
        check_eq("fill_started", ca_read, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_eq("abort_ca_read", ca_read, 1'b0);
        check_eq("abort_ca_write", ca_write, 1'b0);
        mem_read = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b1;
        ds_enable = 1'b1;
        @(posedge clk); #1;
        push_ds(1'b0, 32'h0000_0900, '0);
        access(1'b0, 32'h0000_0900, '0, '0, lat);
        check_eq("post_reset_miss", lat > 1, 1'b1);
        push_ds(1'b0, 32'h0000_0040, '0);
        access(1'b0, 32'h0000_0040, '0, '0, lat);
        check_eq("post_reset_refill", lat > 1, 1'b1);
        check_eq("ds_drained_final", exp_ds.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
